// File: rtl/fan_guard_if.sv
// fan_guard_if: signal bundle between the cooler controller / PWM path
// (master) and the fan supervision stage fan_guard (slave).
interface fan_guard_if;
    logic [11:0] speed_in;
    logic [15:0] rpm;
    logic [11:0] temp;
    logic [11:0] speed_out;
    logic        fault;
    logic        ot;
    logic [1:0]  state;
    logic [7:0]  fault_cnt;

    modport master (
        output speed_in, rpm, temp,
        input  speed_out, fault, ot, state, fault_cnt
    );

    modport slave (
        input  speed_in, rpm, temp,
        output speed_out, fault, ot, state, fault_cnt
    );
endinterface

// File: rtl/fan_guard.sv
// fan_guard: fan supervision between the cooler controller and the PWM stage.
// Enforces a spin-up period, detects a stalled fan from windowed RPM checks,
// and forces full speed on stall (FAULT) or over-temperature.
// Optional build macro FAN_GUARD_KICK_EN: full-speed kick-start during SPINUP.
module fan_guard #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int SPINUP_MS = 2000,
    parameter int CHECK_MS  = 1000,
    parameter int MIN_RPM   = 300,
    parameter int STALL_WIN = 3,
    parameter int TEMP_CRIT = 850
) (
    input  logic        clk,
    input  logic        rstn,
    fan_guard_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SPINUP = 2'd1,
        RUN    = 2'd2,
        FAULT  = 2'd3
    } state_t;

    localparam int             TICK_DIV  = CLK_HZ / 1000;
    localparam int             PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_TOP = PW'(TICK_DIV - 1);
    localparam logic [15:0]    SPIN_LAST = 16'(SPINUP_MS - 1);
    localparam logic [15:0]    WIN_LAST  = 16'(CHECK_MS - 1);
    localparam logic [15:0]    RPM_MIN   = 16'(MIN_RPM);
    localparam logic [7:0]     STALL_LIM = 8'(STALL_WIN);
    localparam logic [11:0]    T_CRIT    = 12'(TEMP_CRIT);
    localparam logic [11:0]    FULL      = 12'hFFF;

    // Saturating event counter: holds at its maximum instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [PW-1:0] presc;
    logic          tick;
    logic [15:0]   ms_cnt;
    logic [7:0]    stall_cnt;
    state_t        st;
    state_t        nxt;
    logic [7:0]    stall_nxt;
    logic [7:0]    stall_inc;
    logic          win_end;
    logic          spin_done;
    logic          rpm_low;
    logic [11:0]   speed_nxt;
    logic [11:0]   speed_out;
    logic          fault;
    logic          ot;
    logic [7:0]    fault_cnt;

    assign tick      = (presc == PRESC_TOP);
    assign win_end   = tick && (ms_cnt == WIN_LAST) && (st == RUN || st == FAULT);
    assign spin_done = tick && (ms_cnt == SPIN_LAST);
    assign rpm_low   = (bus.rpm < RPM_MIN);
    assign stall_inc = stall_cnt + 8'd1;

    // Free-running 1 ms prescaler.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            presc <= '0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
        end
    end

    // Next-state and stall-window decode; a zero command outranks window events.
    always_comb begin
        nxt       = st;
        stall_nxt = stall_cnt;
        case (st)
            IDLE: begin
                if (bus.speed_in != 12'd0) nxt = SPINUP;
            end
            SPINUP: begin
                if (bus.speed_in == 12'd0) begin
                    nxt = IDLE;
                end else if (spin_done) begin
                    nxt       = RUN;
                    stall_nxt = 8'd0;
                end
            end
            RUN: begin
                if (bus.speed_in == 12'd0) begin
                    nxt = IDLE;
                end else if (win_end) begin
                    if (rpm_low) begin
                        stall_nxt = stall_inc;
                        if (stall_inc == STALL_LIM) nxt = FAULT;
                    end else begin
                        stall_nxt = 8'd0;
                    end
                end
            end
            FAULT: begin
                if (win_end && !rpm_low) begin
                    nxt       = RUN;
                    stall_nxt = 8'd0;
                end
            end
        endcase
    end

    // Output speed for the state being entered; a registered over-temp forces full speed.
    always_comb begin
        speed_nxt = 12'd0;
        case (nxt)
            IDLE:   speed_nxt = 12'd0;
`ifdef FAN_GUARD_KICK_EN
            SPINUP: speed_nxt = FULL;
`else
            SPINUP: speed_nxt = bus.speed_in;
`endif
            RUN:    speed_nxt = bus.speed_in;
            FAULT:  speed_nxt = FULL;
        endcase
        if (ot) speed_nxt = FULL;
    end

    // FSM state, ms timer, stall count and all registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st        <= IDLE;
            ms_cnt    <= 16'd0;
            stall_cnt <= 8'd0;
            speed_out <= 12'd0;
            fault     <= 1'b0;
            ot        <= 1'b0;
            fault_cnt <= 8'd0;
        end else begin
            st        <= nxt;
            stall_cnt <= stall_nxt;
            if (nxt != st || win_end) begin
                ms_cnt <= 16'd0;
            end else if (tick) begin
                ms_cnt <= ms_cnt + 16'd1;
            end
            ot        <= (bus.temp >= T_CRIT);
            speed_out <= speed_nxt;
            fault     <= (nxt == FAULT);
            if (nxt == FAULT && st != FAULT) fault_cnt <= sat_inc(fault_cnt);
        end
    end

    assign bus.speed_out = speed_out;
    assign bus.fault     = fault;
    assign bus.ot        = ot;
    assign bus.state     = st;
    assign bus.fault_cnt = fault_cnt;

endmodule

// File: tb/tb_fan_guard.sv
// tb_fan_guard: randomized stimulus with a tick/window reference model and a
// queue-based scoreboard for fan_guard.
module tb_fan_guard;

    localparam int CLK_HZ    = 10000;
    localparam int TICK_CLKS = CLK_HZ / 1000;
    localparam int SPINUP_MS = 5;
    localparam int CHECK_MS  = 4;
    localparam int MIN_RPM   = 300;
    localparam int STALL_WIN = 2;
    localparam int TEMP_CRIT = 850;

    localparam int S_IDLE = 0, S_SPINUP = 1, S_RUN = 2, S_FAULT = 3;

    typedef struct packed {
        logic [11:0] spd;
        logic        flt;
        logic        ot;
        logic [1:0]  st;
        logic [7:0]  fc;
    } exp_t;

    logic clk = 1'b0;
    logic rstn;
    fan_guard_if bus();

    fan_guard #(
        .CLK_HZ(CLK_HZ), .SPINUP_MS(SPINUP_MS), .CHECK_MS(CHECK_MS),
        .MIN_RPM(MIN_RPM), .STALL_WIN(STALL_WIN), .TEMP_CRIT(TEMP_CRIT)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    // Reference model: clock edges since reset, ms ticks since the state was
    // entered (or the last window ended), consecutive low-RPM windows.
    int m_edges, m_state, m_ticks, m_lowrun, m_faults;
    bit m_ot;

    function automatic void model_reset();
        m_edges = 0; m_state = S_IDLE; m_ticks = 0;
        m_lowrun = 0; m_faults = 0; m_ot = 1'b0;
    endfunction

    function automatic void enter(input int s);
        m_state = s;
        m_ticks = 0;
    endfunction

    function automatic exp_t model_step(input int s, input int r, input int t);
        exp_t e;
        bit   tick;
        bit   prev_ot;
        int   spd;
        m_edges++;
        tick    = (m_edges % TICK_CLKS) == 0;
        prev_ot = m_ot;
        case (m_state)
            S_IDLE: if (s != 0) enter(S_SPINUP);
            S_SPINUP: begin
                if (s == 0) enter(S_IDLE);
                else if (tick) begin
                    m_ticks++;
                    if (m_ticks == SPINUP_MS) begin enter(S_RUN); m_lowrun = 0; end
                end
            end
            S_RUN: begin
                if (s == 0) enter(S_IDLE);
                else if (tick) begin
                    m_ticks++;
                    if (m_ticks == CHECK_MS) begin
                        m_ticks = 0;
                        if (r < MIN_RPM) begin
                            m_lowrun++;
                            if (m_lowrun == STALL_WIN) begin
                                enter(S_FAULT);
                                if (m_faults < 255) m_faults++;
                            end
                        end else m_lowrun = 0;
                    end
                end
            end
            default: begin
                if (tick) begin
                    m_ticks++;
                    if (m_ticks == CHECK_MS) begin
                        m_ticks = 0;
                        if (r >= MIN_RPM) begin enter(S_RUN); m_lowrun = 0; end
                    end
                end
            end
        endcase
        case (m_state)
            S_IDLE:   spd = 0;
`ifdef FAN_GUARD_KICK_EN
            S_SPINUP: spd = 4095;
`else
            S_SPINUP: spd = s;
`endif
            S_RUN:    spd = s;
            default:  spd = 4095;
        endcase
        if (prev_ot) spd = 4095;
        m_ot  = (t >= TEMP_CRIT);
        e.spd = 12'(spd);
        e.flt = (m_state == S_FAULT);
        e.ot  = m_ot;
        e.st  = 2'(m_state);
        e.fc  = 8'(m_faults);
        return e;
    endfunction

    function automatic bit would_stall();
        return m_state == S_RUN && ((m_edges + 1) % TICK_CLKS == 0) &&
               (m_ticks + 1 == CHECK_MS) && (m_lowrun + 1 == STALL_WIN);
    endfunction

    function automatic bit would_spin_done();
        return m_state == S_SPINUP && ((m_edges + 1) % TICK_CLKS == 0) &&
               (m_ticks + 1 == SPINUP_MS);
    endfunction

    function automatic int rpm_lo();
        return ($urandom_range(0, 7) == 0) ? 299 : int'($urandom_range(0, 299));
    endfunction
    function automatic int rpm_hi();
        return ($urandom_range(0, 7) == 0) ? 300 : int'($urandom_range(300, 3000));
    endfunction
    function automatic int temp_lo();
        return int'($urandom_range(200, 849));
    endfunction

    // Drive one cycle of inputs on the falling edge and queue the expected result.
    task automatic step(input int s, input int r, input int t);
        @(negedge clk);
        bus.speed_in = 12'(s);
        bus.rpm      = 16'(r);
        bus.temp     = 12'(t);
        q.push_back(model_step(s, r, t));
    endtask

    task automatic run_until(input int target, input bit low, input int s, input int budget);
        int k = 0;
        while (m_state != target && k < budget) begin
            step(s, low ? rpm_lo() : rpm_hi(), temp_lo());
            k++;
        end
        checks++;
        if (m_state != target) begin
            errors++;
            $display("FAIL wait_state: reached=%0d required=%0d", m_state, target);
        end
    endtask

    task automatic check_zero(input string tag);
        checks += 5;
        if (bus.speed_out !== 12'd0) begin errors++; $display("FAIL %s speed_out: got=%0d want=0", tag, bus.speed_out); end
        if (bus.fault !== 1'b0)      begin errors++; $display("FAIL %s fault: got=%b want=0", tag, bus.fault); end
        if (bus.ot !== 1'b0)         begin errors++; $display("FAIL %s ot: got=%b want=0", tag, bus.ot); end
        if (bus.state !== 2'd0)      begin errors++; $display("FAIL %s state: got=%0d want=0", tag, bus.state); end
        if (bus.fault_cnt !== 8'd0)  begin errors++; $display("FAIL %s fault_cnt: got=%0d want=0", tag, bus.fault_cnt); end
    endtask

    // Scoreboard monitor: outputs are registered, so one expectation per clock.
    exp_t mon_e;
    exp_t mon_g;
    always @(posedge clk) begin
        #1;
        if (rstn && q.size() != 0) begin
            mon_e = q.pop_front();
            mon_g = {bus.speed_out, bus.fault, bus.ot, bus.state, bus.fault_cnt};
            checks++;
            if (mon_g !== mon_e) begin
                errors++;
                $display("FAIL out @%0t: got spd=%0d flt=%b ot=%b st=%0d fc=%0d  want spd=%0d flt=%b ot=%b st=%0d fc=%0d",
                         $time, mon_g.spd, mon_g.flt, mon_g.ot, mon_g.st, mon_g.fc,
                         mon_e.spd, mon_e.flt, mon_e.ot, mon_e.st, mon_e.fc);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int  k;
        bit  done;
        rstn = 1'b0;
        bus.speed_in = '0; bus.rpm = '0; bus.temp = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 check_zero("reset");
        @(posedge clk); #2 rstn = 1'b1;

        repeat (5) step(0, rpm_hi(), temp_lo());
        run_until(S_RUN, 1'b0, 2000, 100);
        repeat (50) step(2000, rpm_hi(), temp_lo());

        // Stall, zero command ignored in FAULT, then recovery.
        run_until(S_FAULT, 1'b1, 2000, 200);
        repeat (60) step(0, rpm_lo(), temp_lo());
        run_until(S_RUN, 1'b0, 1500, 100);
        repeat (40) step(1500, 100, temp_lo());
        repeat (80) step(1500, 500, temp_lo());

        // Over-temperature in RUN.
        repeat (10) step(1000, rpm_hi(), 900);
        repeat (10) step(1000, rpm_hi(), 849);
        repeat (4)  step(1000, rpm_hi(), 850);
        repeat (4)  step(1000, rpm_hi(), 849);

        // Command off in RUN.
        repeat (20) step(0, rpm_hi(), temp_lo());

        // Zero command coinciding with spin-up completion.
        step(700, rpm_hi(), temp_lo());
        k = 0;
        while (!would_spin_done() && k < 100) begin step(700, rpm_hi(), temp_lo()); k++; end
        step(0, rpm_hi(), temp_lo());
        repeat (5) step(0, rpm_hi(), temp_lo());

        // Zero command on the stall-completing window end.
        run_until(S_RUN, 1'b0, 800, 100);
        done = 1'b0;
        k = 0;
        while (!done && k < 200) begin
            if (would_stall()) begin step(0, 100, temp_lo()); done = 1'b1; end
            else step(800, 100, temp_lo());
            k++;
        end
        checks++;
        if (!done) begin errors++; $display("FAIL sim_stall_wait: reached=0 required=1"); end
        repeat (10) step(0, rpm_hi(), temp_lo());

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            int s, r, t;
            s = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 4095));
            r = ($urandom_range(0, 1) == 0) ? rpm_lo() : rpm_hi();
            t = ($urandom_range(0, 5) == 0) ? int'($urandom_range(840, 900)) : temp_lo();
            step(s, r, t);
        end

        // Drive fault_cnt into saturation and past it.
        run_until(S_RUN, 1'b0, 900, 200);
        for (int i = 0; i < 258; i++) begin
            run_until(S_FAULT, 1'b1, 900, 200);
            run_until(S_RUN, 1'b0, 900, 100);
        end

        // Asynchronous reset in the middle of FAULT with ot set.
        run_until(S_FAULT, 1'b1, 900, 200);
        repeat (3) step(900, rpm_lo(), 900);
        @(negedge clk); #2 rstn = 1'b0;
        #1 check_zero("midreset");
        q.delete();
        repeat (2) @(posedge clk);
        #2 rstn = 1'b1;
        model_reset();
        run_until(S_RUN, 1'b0, 1234, 100);
        repeat (20) step(1234, rpm_hi(), temp_lo());

        @(posedge clk); #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fan_guard.md
# fan_guard

Fan supervision stage between the temperature-target cooler controller and the PWM output stage. It takes the commanded 12-bit fan speed and the measured fan RPM, enforces a spin-up period, and detects a stalled fan. On stall or over-temperature it overrides the command to full speed and raises status flags. `speed_out` drives `pwm_output.speed`. Status outputs are available for the OLED/7-segment debug path.

## Interface
- `CLK_HZ`, 50_000_000, system clock frequency; sets the 1 ms tick prescaler.
- `SPINUP_MS`, 2000, ms after a 0 → non-zero command before stall checking starts.
- `CHECK_MS`, 1000, length of the RPM evaluation window in ms.
- `MIN_RPM`, 300, minimum acceptable `rpm` at a window end.
- `STALL_WIN`, 3, consecutive low-RPM windows that declare a stall (≥1).
- `TEMP_CRIT`, 850, critical temperature in 0.1 °C units (85.0 °C).
- `clk`  in  1  system clock.
- `rstn`  in  1  asynchronous active-low reset.
- `speed_in`  in  12  commanded speed from the cooler controller; 0 = fan off, 4095 = full.
- `rpm`  in  16  measured RPM from the fan RPM counter.
- `temp`  in  12  die temperature in 0.1 °C units.
- `speed_out`  out  12  supervised speed to the PWM stage (registered).
- `fault`  out  1  high while in FAULT (registered).
- `ot`  out  1  high while `temp >= TEMP_CRIT` (registered).
- `state`  out  2  IDLE=0, SPINUP=1, RUN=2, FAULT=3.
- `fault_cnt`  out  8  number of FAULT entries since reset; saturates at 255.

## Operation
- **1 ms tick:** prescaler counts 0..CLK_HZ/1000−1 and emits a one-cycle `tick` at terminal count. It free-runs from reset.
- **ms_cnt:** shared 16-bit ms counter. Cleared on every state entry and on each window end. Increments on `tick`.
- **win_end:** one-cycle event when `tick` occurs with ms_cnt == CHECK_MS−1. Only meaningful in RUN and FAULT.
- **IDLE:**
  - `speed_out` = 0.
  - `speed_in != 0` → SPINUP.
- **SPINUP:**
  - `speed_out` = `speed_in`.
  - `speed_in == 0` → IDLE.
  - `tick` with ms_cnt == SPINUP_MS−1 → RUN, stall_cnt = 0.
- **RUN:**
  - `speed_out` = `speed_in`.
  - `speed_in == 0` → IDLE (highest priority).
  - On `win_end`: if `rpm < MIN_RPM`, stall_cnt++; otherwise stall_cnt = 0.
  - If the incremented stall_cnt == STALL_WIN → FAULT and `fault_cnt`++.
- **FAULT:**
  - `speed_out` = 4095, `fault` = 1.
  - `speed_in` is ignored; a zero command does not exit FAULT.
  - On `win_end` with `rpm >= MIN_RPM` → RUN, stall_cnt = 0, `fault` clears.
- **Over-temperature:**
  - `ot` is registered from `temp >= TEMP_CRIT` (unsigned compare).
  - While `ot` = 1, `speed_out` = 4095 in every state.
  - The state machine keeps running unaffected; `ot` does not enter FAULT.
- **Widths:** stall_cnt is 8 bits. All compares are unsigned; `rpm` is compared at full 16 bits.

## Timing
- **Reset values:** `speed_out` = 0, `fault` = 0, `ot` = 0, `state` = IDLE, `fault_cnt` = 0, prescaler = 0, ms_cnt = 0, stall_cnt = 0.
- **Registered outputs:** all outputs are registered. Latency is 1 clk from an input change to `speed_out`/`state`/`fault`.
- **`ot` path:** `ot` is registered one cycle after `temp`. The forced `speed_out` follows one cycle after `ot`, i.e. 2 clk from `temp`.
- **RPM sampling:** `rpm` is sampled only in the `win_end` cycle. Values between window ends are don't-care.
- **Simultaneous events:**
  - In RUN, `speed_in == 0` in the same cycle as a stall-completing `win_end` → IDLE; no FAULT and no `fault_cnt` increment.
  - In SPINUP, `speed_in == 0` coinciding with spin-up completion → IDLE.
- **Reset mid-operation:** all state returns to reset values immediately (asynchronous), including a pending FAULT. `fault_cnt` resets.
- **`fault_cnt` saturation:** at 255 the FAULT entry still occurs, but the count holds at 255.

## Configuration
- **`FAN_GUARD_KICK_EN`**
  - Defined: in SPINUP, `speed_out` = 4095 for the whole spin-up period (kick-start). RUN, FAULT, and IDLE behave as above.
  - Undefined: in SPINUP, `speed_out` = `speed_in`.
  - All other behaviour is identical in both builds.

## Test plan
Bench parameters: CLK_HZ=10000 (tick every 10 clk), SPINUP_MS=5, CHECK_MS=4, STALL_WIN=2, MIN_RPM=300, TEMP_CRIT=850.

- **Reset then spin-up:** release reset, `speed_in`=2000 → IDLE→SPINUP 1 clk later, RUN after 5 ticks. `speed_out`=2000, or 4095 during SPINUP with `FAN_GUARD_KICK_EN`.
- **Stall detection:** in RUN, `rpm`=100 for 2 windows → FAULT at the second `win_end`+1 clk. `speed_out`=4095, `fault`=1, `fault_cnt`=1.
- **Recovery:** in FAULT, `rpm`=1200 at the next `win_end` → RUN, `fault`=0, `speed_out`=`speed_in`. One low window (`rpm`=100) followed by one good window (`rpm`=500) → stays in RUN.
- **Command off:** `speed_in`=0 during RUN → IDLE, `speed_out`=0. The same stimulus in FAULT → remains in FAULT with `speed_out`=4095.
- **Over-temperature:** `temp`=900 in RUN with `speed_in`=1000 → `ot`=1 after 1 clk, `speed_out`=4095 after 2 clk. `temp`=849 → `ot`=0, `speed_out`=1000, and the state stays RUN throughout.
- **Simultaneous events and reset:** `speed_in`=0 on the stall-completing `win_end` → IDLE, `fault_cnt` unchanged. Assert `rstn`=0 mid-FAULT → all outputs are 0 immediately.
